// File: rtl/activation_sequencer.sv
// Buffers one DESIGN_SIZE-row tile from the matmul stream and bursts it gap-free
// into the activation block. Activated rows are then written out to output memory.
module activation_sequencer #(
  parameter int unsigned DESIGN_SIZE   = 4,
  parameter int unsigned DWIDTH        = 8,
  parameter int unsigned MASK_WIDTH    = 4,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned DRAIN_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          cfg_enable,
  input  logic                          cfg_type,
  input  logic [MASK_WIDTH-1:0]         cfg_mask,
  input  logic [ADDR_WIDTH-1:0]         cfg_base_addr,
  input  logic                          up_valid,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] up_data,
  output logic                          up_ready,
  output logic                          act_enable,
  output logic                          act_type,
  output logic [MASK_WIDTH-1:0]         act_mask,
  output logic                          act_in_data_available,
  output logic [DESIGN_SIZE*DWIDTH-1:0] act_inp_data,
  input  logic                          act_out_data_available,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] act_out_data,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DESIGN_SIZE*DWIDTH-1:0] wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout
);

  localparam int unsigned RowW = DESIGN_SIZE * DWIDTH;
  localparam int unsigned CntW = $clog2(DESIGN_SIZE + 1);
  localparam int unsigned IdxW = (DESIGN_SIZE > 1) ? $clog2(DESIGN_SIZE) : 1;
  localparam int unsigned TmrW = $clog2(DESIGN_SIZE + DRAIN_TIMEOUT + 2) + 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(DESIGN_SIZE);
  localparam logic [CntW-1:0] CntLast  = CntW'(DESIGN_SIZE - 1);
  localparam logic [TmrW-1:0] TmrLimit = TmrW'(DESIGN_SIZE + DRAIN_TIMEOUT);

  typedef enum logic [2:0] {StIdle, StCollect, StBurst, StDrain, StFin} state_e;

  state_e                state_q;
  logic [RowW-1:0]       buffer_q [DESIGN_SIZE];
  logic [CntW-1:0]       in_cnt_q;
  logic [CntW-1:0]       rd_cnt_q;
  logic [CntW-1:0]       out_cnt_q;
  logic [TmrW-1:0]       tmr_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  in_fire;
  logic                  out_fire;

  assign up_ready = (state_q == StCollect) && (in_cnt_q < CntMax);
  assign in_fire  = up_valid && up_ready;
  assign busy     = (state_q != StIdle);
  // Outputs can already arrive during the burst (bypass/ReLU), so count them there too.
  assign out_fire = act_out_data_available && (out_cnt_q < CntMax) &&
                    ((state_q == StBurst) || (state_q == StDrain));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q               <= StIdle;
      in_cnt_q              <= '0;
      rd_cnt_q              <= '0;
      out_cnt_q             <= '0;
      tmr_q                 <= '0;
      base_q                <= '0;
      act_enable            <= 1'b0;
      act_type              <= 1'b0;
      act_mask              <= '0;
      act_in_data_available <= 1'b0;
      act_inp_data          <= '0;
      wr_en                 <= 1'b0;
      wr_addr               <= '0;
      wr_data               <= '0;
      done                  <= 1'b0;
      err_timeout           <= 1'b0;
      for (int unsigned i = 0; i < DESIGN_SIZE; i++) buffer_q[i] <= '0;
    end else begin
      act_in_data_available <= 1'b0;
      wr_en                 <= 1'b0;
      done                  <= 1'b0;
      if (abort) begin
        // Abort beats every transition, including a start in IDLE; err_timeout is kept.
        state_q    <= StIdle;
        in_cnt_q   <= '0;
        rd_cnt_q   <= '0;
        out_cnt_q  <= '0;
        tmr_q      <= '0;
        act_enable <= 1'b0;
        act_type   <= 1'b0;
        act_mask   <= '0;
        for (int unsigned i = 0; i < DESIGN_SIZE; i++) buffer_q[i] <= '0;
      end else begin
        if (out_fire) begin
          wr_en     <= 1'b1;
          wr_data   <= act_out_data;
          wr_addr   <= base_q + ADDR_WIDTH'(out_cnt_q);
          out_cnt_q <= out_cnt_q + 1'b1;
        end
        case (state_q)
          StIdle: begin
            if (start) begin
              act_enable  <= cfg_enable;
              act_type    <= cfg_type;
              act_mask    <= cfg_mask;
              base_q      <= cfg_base_addr;
              err_timeout <= 1'b0;
              state_q     <= StCollect;
            end
          end
          StCollect: begin
            if (in_fire) begin
              buffer_q[in_cnt_q[IdxW-1:0]] <= up_data;
              in_cnt_q                     <= in_cnt_q + 1'b1;
              if (in_cnt_q == CntLast) begin
                state_q <= StBurst;
                tmr_q   <= '0;
              end
            end
          end
          StBurst: begin
            act_in_data_available <= 1'b1;
            act_inp_data          <= buffer_q[rd_cnt_q[IdxW-1:0]];
            rd_cnt_q              <= rd_cnt_q + 1'b1;
            tmr_q                 <= tmr_q + 1'b1;
            if (rd_cnt_q == CntLast) state_q <= StDrain;
          end
          StDrain: begin
            tmr_q <= tmr_q + 1'b1;
            if ((out_fire && (out_cnt_q == CntLast)) || (out_cnt_q == CntMax)) begin
              state_q <= StFin;
              done    <= 1'b1;
            end else if (tmr_q > TmrLimit) begin
              err_timeout <= 1'b1;
              state_q     <= StFin;
              done        <= 1'b1;
            end
          end
          StFin: begin
            state_q    <= StIdle;
            in_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            tmr_q      <= '0;
            act_enable <= 1'b0;
            act_type   <= 1'b0;
            act_mask   <= '0;
            for (int unsigned i = 0; i < DESIGN_SIZE; i++) buffer_q[i] <= '0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_activation_sequencer.sv
// Bench for activation_sequencer: a stub activation block with ReLU/tanh/bypass latencies
// and a reference model of the expected burst, writes, done and timeout behaviour.
module tb_activation_sequencer;

  localparam int DS   = 4;
  localparam int DW   = 8;
  localparam int MW   = 4;
  localparam int AW   = 10;
  localparam int DT   = 8;
  localparam int RowW = DS * DW;

  logic            clk;
  logic            reset;
  logic            start;
  logic            abort;
  logic            cfg_enable;
  logic            cfg_type;
  logic [MW-1:0]   cfg_mask;
  logic [AW-1:0]   cfg_base_addr;
  logic            up_valid;
  logic [RowW-1:0] up_data;
  logic            up_ready;
  logic            act_enable;
  logic            act_type;
  logic [MW-1:0]   act_mask;
  logic            act_in_data_available;
  logic [RowW-1:0] act_inp_data;
  logic            act_out_data_available;
  logic [RowW-1:0] act_out_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [RowW-1:0] wr_data;
  logic            busy;
  logic            done;
  logic            err_timeout;

  activation_sequencer #(
    .DESIGN_SIZE  (DS),
    .DWIDTH       (DW),
    .MASK_WIDTH   (MW),
    .ADDR_WIDTH   (AW),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .abort                 (abort),
    .cfg_enable            (cfg_enable),
    .cfg_type              (cfg_type),
    .cfg_mask              (cfg_mask),
    .cfg_base_addr         (cfg_base_addr),
    .up_valid              (up_valid),
    .up_data               (up_data),
    .up_ready              (up_ready),
    .act_enable            (act_enable),
    .act_type              (act_type),
    .act_mask              (act_mask),
    .act_in_data_available (act_in_data_available),
    .act_inp_data          (act_inp_data),
    .act_out_data_available(act_out_data_available),
    .act_out_data          (act_out_data),
    .wr_en                 (wr_en),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .busy                  (busy),
    .done                  (done),
    .err_timeout           (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Per-word activation used both by the stub and by the expected-value model.
  function automatic logic [RowW-1:0] act_fn(input logic [RowW-1:0] row, input logic en,
                                             input logic typ);
    logic [RowW-1:0]        r;
    logic signed [DW-1:0]   w;
    r = row;
    if (en) begin
      for (int k = 0; k < DS; k++) begin
        w = row[k*DW +: DW];
        if (!typ) r[k*DW +: DW] = (w < 0) ? '0 : w;
        else      r[k*DW +: DW] = w >>> 1;
      end
    end
    return r;
  endfunction

  // Stub activation block: bypass 0 cycles, ReLU 1 cycle, tanh 2 cycles.
  logic            stub_dead = 1'b0;
  logic            v1 = 1'b0, v2 = 1'b0;
  logic [RowW-1:0] d1 = '0, d2 = '0;

  always @(posedge clk) begin
    v1 <= act_in_data_available;
    d1 <= act_fn(act_inp_data, act_enable, act_type);
    v2 <= v1;
    d2 <= d1;
  end

  always_comb begin
    act_out_data_available = 1'b0;
    act_out_data           = '0;
    if (!stub_dead) begin
      if (!act_enable) begin
        act_out_data_available = act_in_data_available;
        act_out_data           = act_inp_data;
      end else if (!act_type) begin
        act_out_data_available = v1;
        act_out_data           = d1;
      end else begin
        act_out_data_available = v2;
        act_out_data           = d2;
      end
    end
  end

  // Monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit              mon_on = 1'b0;
  int              b_cyc[$];
  logic [RowW-1:0] b_dat[$];
  int              w_cyc[$];
  logic [AW-1:0]   w_addr[$];
  logic [RowW-1:0] w_dat[$];
  int              done_cnt = 0;
  int              err_cyc  = -1;
  logic            err_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (act_in_data_available) begin
        b_cyc.push_back(cyc);
        b_dat.push_back(act_inp_data);
      end
      if (wr_en) begin
        w_cyc.push_back(cyc);
        w_addr.push_back(wr_addr);
        w_dat.push_back(wr_data);
      end
      if (done) done_cnt++;
      if (err_timeout && !err_prev) err_cyc = cyc;
    end
    err_prev = err_timeout;
  end

  task automatic mon_reset();
    b_cyc.delete(); b_dat.delete();
    w_cyc.delete(); w_addr.delete(); w_dat.delete();
    done_cnt = 0;
    err_cyc  = -1;
    mon_on   = 1'b1;
  endtask

  typedef struct {
    logic          en;
    logic          typ;
    logic [MW-1:0] mask;
    logic [AW-1:0] base;
    bit            zero;
    bit            gaps;
    bit            dead;
    int            exp_lat;
    bit            exp_err;
  } tile_t;

  logic [RowW-1:0] rows_m [DS];

  task automatic make_rows(input bit zero);
    for (int k = 0; k < DS; k++) rows_m[k] = zero ? '0 : RowW'($urandom);
    // Guarantee at least one negative word so ReLU clipping is visible.
    if (!zero) rows_m[0][DW-1:0] = 8'h81;
  endtask

  task automatic feed(input int cnt, input bit gaps);
    int i     = 0;
    int guard = 0;
    while (i < cnt && guard < 100) begin
      up_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      up_data  = rows_m[i];
      if (up_valid && up_ready) begin
        @(negedge clk);
        i++;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    up_valid = 1'b0;
    chk("feed_complete", i, cnt);
  endtask

  task automatic do_start(input tile_t t);
    start         = 1'b1;
    cfg_enable    = t.en;
    cfg_type      = t.typ;
    cfg_mask      = t.mask;
    cfg_base_addr = t.base;
    @(negedge clk);
    start = 1'b0;
    chk("act_enable_latched", act_enable, t.en);
    chk("act_type_latched", act_type, t.typ);
    chk("act_mask_latched", act_mask, t.mask);
    chk("err_cleared_on_start", err_timeout, 0);
    chk("busy_after_start", busy, 1);
    // Scramble the config inputs; the latched copy must not follow them.
    cfg_enable    = ~t.en;
    cfg_type      = ~t.typ;
    cfg_mask      = ~t.mask;
    cfg_base_addr = ~t.base;
  endtask

  task automatic run_tile(input tile_t t);
    int n = 0;
    make_rows(t.zero);
    stub_dead = t.dead;
    mon_reset();
    do_start(t);
    feed(DS, t.gaps);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("busy_in_fin", busy, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("act_enable_cleared", act_enable, 0);
    mon_on = 1'b0;
    chk("burst_len", b_cyc.size(), DS);
    for (int k = 0; k < b_cyc.size() && k < DS; k++) begin
      chk("burst_gapfree", b_cyc[k] - b_cyc[0], k);
      chk("burst_data", b_dat[k], rows_m[k]);
    end
    chk("wr_count", w_cyc.size(), t.dead ? 0 : DS);
    for (int k = 0; k < w_cyc.size() && k < DS; k++) begin
      chk("wr_addr", w_addr[k], (int'(t.base) + k) % (1 << AW));
      chk("wr_data", w_dat[k], act_fn(rows_m[k], t.en, t.typ));
    end
    if (w_cyc.size() > 0 && b_cyc.size() > 0) chk("wr_latency", w_cyc[0] - b_cyc[0], t.exp_lat);
    chk("done_once", done_cnt, 1);
    chk("err_timeout", err_timeout, t.exp_err);
    if (t.dead && b_cyc.size() > 0) chk("err_cycle", err_cyc - b_cyc[0], DS + DT + 1);
    stub_dead = 1'b0;
  endtask

  function automatic int model_lat(input logic en, input logic typ);
    int lat;
    lat = !en ? 0 : (typ ? 2 : 1);
    return lat + 1;
  endfunction

  tile_t tbl [5];
  tile_t t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_enable = 1'b0; cfg_type = 1'b0; cfg_mask = '0; cfg_base_addr = '0;
    up_valid = 1'b0; up_data = '0;

    //        en typ mask   base     zero gaps dead lat err
    tbl[0] = '{1'b1, 1'b0, 4'hF, 10'h010, 1'b0, 1'b1, 1'b0, 2, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'hA, 10'h100, 1'b1, 1'b0, 1'b0, 3, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 4'h3, 10'h3FE, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 4'h5, 10'h080, 1'b0, 1'b0, 1'b1, 2, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 4'h9, 10'h3FD, 1'b0, 1'b1, 1'b0, 3, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_up_ready", up_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_act_enable", act_enable, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 5; i++) run_tile(tbl[i]);

    // Randomised tiles; expected first-write offset from the activation latency rules.
    for (int r = 0; r < 6; r++) begin
      t.en      = 1'($urandom_range(0, 1));
      t.typ     = 1'($urandom_range(0, 1));
      t.mask    = MW'($urandom);
      t.base    = AW'($urandom);
      t.zero    = 1'b0;
      t.gaps    = 1'b1;
      t.dead    = 1'b0;
      t.exp_lat = model_lat(t.en, t.typ);
      t.exp_err = 1'b0;
      run_tile(t);
    end

    // Abort after two rows collected.
    make_rows(1'b0);
    mon_reset();
    do_start(tbl[0]);
    feed(2, 1'b0);
    chk("ready_before_abort", up_ready, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_up_ready", up_ready, 0);
    chk("abort_busy", busy, 0);
    repeat (10) @(negedge clk);
    mon_on = 1'b0;
    chk("abort_no_wr", w_cyc.size(), 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_burst", b_cyc.size(), 0);
    run_tile(tbl[2]);

    // start with abort in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 0);

    // start ignored during BURST, then asynchronous reset mid-burst.
    make_rows(1'b0);
    mon_reset();
    do_start(tbl[0]);
    feed(DS, 1'b0);
    for (int n = 0; n < 10 && !act_in_data_available; n++) @(negedge clk);
    chk("burst_started", act_in_data_available, 1);
    start      = 1'b1;
    cfg_enable = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_ign_busy", busy, 1);
    chk("start_ign_act_en", act_enable, 1);
    chk("start_ign_burst", act_in_data_available, 1);
    #1 reset = 1'b0;
    #1;
    chk("rb_up_ready", up_ready, 0);
    chk("rb_act_enable", act_enable, 0);
    chk("rb_act_mask", act_mask, 0);
    chk("rb_act_in", act_in_data_available, 0);
    chk("rb_act_inp_data", act_inp_data, 0);
    chk("rb_wr_en", wr_en, 0);
    chk("rb_wr_addr", wr_addr, 0);
    chk("rb_wr_data", wr_data, 0);
    chk("rb_busy", busy, 0);
    chk("rb_done", done, 0);
    chk("rb_err", err_timeout, 0);
    mon_on = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    run_tile(tbl[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
